// File: rtl/psp_check.sv
// Self-synchronizing checker for the x^8+x^4+x^3+x^2+1 PRBS: locks onto the stream,
// then flywheels on its own prediction while counting bit errors and checked bits.
module psp_check #(
  parameter int LOCK_COUNT = 16,
  parameter int WINDOW     = 64,
  parameter int LOSS_ERRS  = 8,
  parameter int ERR_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             din_i,
  input  logic             din_valid_i,
  input  logic             clr_err_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [ERR_W-1:0] bit_cnt_o
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int BW = $clog2(LOSS_ERRS + 1);

  typedef enum logic {SEARCH, LOCKED} state_e;

  state_e           state_q;
  logic [7:0]       hist_q;
  logic [3:0]       fill_q;
  logic [MW-1:0]    match_q;
  logic [WW-1:0]    win_q;
  logic [BW-1:0]    bad_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [ERR_W-1:0] bit_cnt_q;
  logic             err_q;
  logic             locked_q;

  logic          pred;
  logic          miss;
  logic [MW-1:0] match_d;
  logic [WW-1:0] win_d;
  logic [BW-1:0] bad_d;

  // hist_q[0] is the most recent bit; the taps implement s[n-4]^s[n-5]^s[n-6]^s[n-8].
  assign pred    = hist_q[3] ^ hist_q[4] ^ hist_q[5] ^ hist_q[7];
  assign miss    = din_i ^ pred;
  assign match_d = match_q + MW'(1);
  assign win_d   = win_q + WW'(1);
  assign bad_d   = bad_q + {{(BW-1){1'b0}}, miss};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SEARCH;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      win_q     <= '0;
      bad_q     <= '0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (din_valid_i) begin
        case (state_q)
          SEARCH: begin
            hist_q <= {hist_q[6:0], din_i};
            if (fill_q != 4'd8) begin
              fill_q <= fill_q + 4'd1;
            end else if (miss || hist_q == 8'h00) begin
              // An all-zero history is not a legal PRBS state; refusing it keeps stuck-at-0 unlocked.
              match_q <= '0;
            end else begin
              match_q <= match_d;
              if (match_d == MW'(LOCK_COUNT)) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                win_q    <= '0;
                bad_q    <= '0;
              end
            end
          end
          LOCKED: begin
            // Flywheel on the prediction so a single line error costs exactly one mismatch.
            hist_q <= {hist_q[6:0], pred};
            if (bit_cnt_q != '1) bit_cnt_q <= bit_cnt_q + ERR_W'(1);
            if (miss) begin
              err_q <= 1'b1;
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_W'(1);
            end
            if (bad_d == BW'(LOSS_ERRS)) begin
              state_q  <= SEARCH;
              locked_q <= 1'b0;
              fill_q   <= '0;
              match_q  <= '0;
              win_q    <= '0;
              bad_q    <= '0;
            end else if (win_d == WW'(WINDOW)) begin
              win_q <= '0;
              bad_q <= '0;
            end else begin
              win_q <= win_d;
              bad_q <= bad_d;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
      if (clr_err_i) begin
        err_cnt_q <= '0;
        bit_cnt_q <= '0;
      end
    end
  end

  assign locked_o  = locked_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;
  assign bit_cnt_o = bit_cnt_q;

endmodule
